multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM for the multi-cycle RV32I core. It fetches each instruction over a req/ready memory handshake and decodes the IR opcode fields. It then steps the shared datapath (register file, ALU, ALUOut register, immediate extender, PC) through per-class state sequences. It is the sole driver of the immediate extender's format select and of every datapath write enable.

## Interface
Parameters:
- none; all encodings come from `riscv_ctrl_pkg`.

Ports:
- `clk`  in  1  — single clock; all state changes on rising edge.
- `rstN`  in  1  — synchronous, active-low reset.
- `opcode`  in  7  — IR[6:0].
- `funct3`  in  3  — IR[14:12].
- `funct7_5`  in  1  — IR[30].
- `zero`, `lt`, `ltu`  in  1 each  — ALU flags for rs1−rs2 (equal, signed less, unsigned less).
- `mem_ready`  in  1  — memory completes the current request this cycle.
- `mem_req`  out  1  — memory request.
- `mem_we`  out  1  — request is a write.
- `addr_sel`  out  1  — 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  — latch IR and OldPC.
- `pc_write`  out  1  — update PC.
- `pc_src`  out  1  — 0 = live ALU result, 1 = ALUOut.
- `reg_write`  out  1  — register-file write.
- `wb_sel`  out  2  — 0 = ALUOut, 1 = mem data, 2 = PC.
- `imm_sel`  out  3  — I / S / SB / U / UJ.
- `alu_src_a`  out  2  — 0 = PC, 1 = OldPC, 2 = rs1, 3 = zero.
- `alu_src_b`  out  2  — 0 = rs2, 1 = imm, 2 = const 4.
- `alu_ctrl`  out  4  — ALU operation.
- `illegal`  out  1  — sticky trap flag.

## Operation
- Outputs are a pure decode of state, with two exceptions: `ir_write`/`pc_write` also depend on `mem_ready` (FETCH) and on the flags (BRANCH).
- Any output not listed for a state is 0.
- FETCH: `mem_req`=1, `addr_sel`=0, a=PC, b=4, ADD.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0 → DECODE.
  - Otherwise hold FETCH.
- DECODE: a=OldPC, b=imm, `imm_sel`=SB, ADD (branch target into ALUOut). Dispatch on opcode:
  - LOAD / STORE → MEM_ADDR
  - OP → EXEC_R
  - OP_IMM → EXEC_I
  - BRANCH → BRANCH
  - JAL → JAL
  - JALR → JALR
  - LUI → LUI
  - AUIPC → AUIPC
  - any other opcode → TRAP
- MEM_ADDR: a=rs1, b=imm, ADD; `imm_sel`=I for LOAD, S for STORE. Next MEM_RD (LOAD) or MEM_WR (STORE).
- MEM_RD: `mem_req`=1, `addr_sel`=1; hold until `mem_ready` → WB_MEM.
- MEM_WR: `mem_req`=1, `mem_we`=1, `addr_sel`=1; hold until `mem_ready` → FETCH.
- WB_MEM: `reg_write`=1, `wb_sel`=1 → FETCH.
- EXEC_R: a=rs1, b=rs2, `alu_ctrl` from funct3/funct7_5 → WB_ALU.
- EXEC_I: a=rs1, b=imm(I). `funct7_5` is honoured only for funct3=101 (SRAI/SRLI) → WB_ALU.
- LUI: a=zero, b=imm(U) → WB_ALU.
- AUIPC: a=OldPC, b=imm(U) → WB_ALU.
- WB_ALU: `reg_write`=1, `wb_sel`=0 → FETCH.
- BRANCH: a=rs1, b=rs2, SUB. Taken when:
  - funct3 000: `zero`
  - funct3 001: !`zero`
  - funct3 100: `lt`
  - funct3 101: !`lt`
  - funct3 110: `ltu`
  - funct3 111: !`ltu`
  - If taken: `pc_write`=1, `pc_src`=1. Next state FETCH.
  - funct3 010/011: no PC write → TRAP.
- JAL: `reg_write`=1, `wb_sel`=2 (PC, already OldPC+4); a=OldPC, b=imm(UJ), ADD; `pc_write`=1, `pc_src`=0 → FETCH.
- JALR: same as JAL except a=rs1, `imm_sel`=I; bit 0 of the target is cleared in the datapath. funct3≠000 → TRAP.
- TRAP: `illegal`=1, all enables 0. Held until reset.

## Timing
- Reset: `rstN`=0 at an edge → FETCH, `illegal`=0, from any state, including mid memory wait.
  - Resulting outputs: `mem_req`=1, `alu_src_b`=2, all write enables 0 until `mem_ready`.
- Cycles after fetch completes:
  - R / I / LUI / AUIPC: 3
  - LOAD: 4 + memory wait
  - STORE: 3 + memory wait
  - BRANCH, JAL, JALR: 2
- A zero-wait fetch takes 1 cycle.
- `mem_req` holds constant with stable `addr_sel`/`mem_we` until `mem_ready`.
- `mem_ready` while `mem_req`=0 is ignored.
- JAL/JALR register write and PC write happen in the same cycle. The register file captures the pre-update PC.

## Structure
- `riscv_ctrl_pkg` holds:
  - `state_t`
  - `imm_sel_t` (I=0, S=1, SB=2, U=3, UJ=4)
  - `alu_ctrl_t`
  - `alu_src_a_t`, `alu_src_b_t`, `wb_sel_t`
  - RV32I opcode constants
- One sub-module, `alu_decoder`: {class, funct3, funct7_5} → `alu_ctrl`.

## Test plan
- Reset, then ADD with `mem_ready` tied 1 → `ir_write` in cycle 1, `reg_write`=1 with `wb_sel`=0 in cycle 4, FETCH in cycle 5.
- LW with `mem_ready` delayed 3 cycles in MEM_RD → `mem_req`/`addr_sel`=1 held 3 cycles; WB_MEM `reg_write`=1, `wb_sel`=1.
- BEQ with `zero`=1, then BNE with `zero`=1 → first: `pc_write`=1, `pc_src`=1. Second: `pc_write`=0. DECODE `imm_sel`=SB both times.
- JAL → single cycle with `reg_write`=1, `wb_sel`=2, `pc_write`=1, `imm_sel`=UJ. JALR funct3=001 → TRAP, `illegal`=1.
- Opcode 7'b0000000 → TRAP; `illegal` stays 1 for 10 cycles; `rstN`=0 for one edge → FETCH, `illegal`=0.
- `rstN` low during a MEM_WR wait → next cycle FETCH, `mem_we`=0, `addr_sel`=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// datapath select codes, ALU operations and the RV32I major opcodes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
    S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_WB_ALU, S_BRANCH,
    S_JAL, S_JALR, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_SB = 3'd2,
    IMM_U  = 3'd3,
    IMM_UJ = 3'd4
  } imm_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {A_PC = 2'd0, A_OLDPC = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3} alu_src_a_t;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} alu_src_b_t;
  typedef enum logic [1:0] {WB_ALUOUT = 2'd0, WB_MEMDATA = 2'd1, WB_PC = 2'd2} wb_sel_t;

  // Which family of ALU operation the current state wants.
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/alu_decoder.sv
// Maps {operation class, funct3, funct7[5]} to an ALU operation code.
// Immediate forms only look at funct7[5] for the shift-right pair.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_t i_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output alu_ctrl_t  o_alu_ctrl
);

  // Pure combinational operation select.
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_class)
      CLS_ADD: o_alu_ctrl = ALU_ADD;
      CLS_SUB: o_alu_ctrl = ALU_SUB;
      default: begin
        case (i_funct3)
          3'b000: begin
            if (i_class == CLS_R && i_funct7_5) o_alu_ctrl = ALU_SUB;
            else                                o_alu_ctrl = ALU_ADD;
          end
          3'b001: o_alu_ctrl = ALU_SLL;
          3'b010: o_alu_ctrl = ALU_SLT;
          3'b011: o_alu_ctrl = ALU_SLTU;
          3'b100: o_alu_ctrl = ALU_XOR;
          3'b101: begin
            if (i_funct7_5) o_alu_ctrl = ALU_SRA;
            else            o_alu_ctrl = ALU_SRL;
          end
          3'b110: o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core. Fetches over a req/ready
// handshake, dispatches on the opcode and sequences the shared datapath.
// Only FETCH (mem_ready) and BRANCH (ALU flags) gate outputs on inputs.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  alu_class_t w_class;
  alu_ctrl_t  w_alu_ctrl;

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic l, input logic lu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      3'b110:  return lu;
      3'b111:  return !lu;
      default: return 1'b0;
    endcase
  endfunction

  // State register; reset lands in FETCH from anywhere, even mid memory wait.
  always_ff @(posedge clk) begin
    if (!rstN) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // ALU operation family implied by the current state.
  always_comb begin
    w_class = CLS_ADD;
    case (r_state)
      S_EXEC_R: w_class = CLS_R;
      S_EXEC_I: w_class = CLS_I;
      S_BRANCH: w_class = CLS_SUB;
      default:  w_class = CLS_ADD;
    endcase
  end

  alu_decoder u_alu_dec (
    .i_class    (w_class),
    .i_funct3   (funct3),
    .i_funct7_5 (funct7_5),
    .o_alu_ctrl (w_alu_ctrl)
  );

  assign alu_ctrl = w_alu_ctrl;
  assign illegal  = (r_state == S_TRAP);

  // Next-state and datapath control decode; everything defaults to 0.
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    imm_sel   = IMM_I;
    alu_src_a = A_PC;
    alu_src_b = B_RS2;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = A_PC;
        alu_src_b = B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        imm_sel   = IMM_SB;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_OP:             w_next = S_EXEC_R;
          OP_OPIMM:          w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        if (opcode == OP_STORE) begin
          imm_sel = IMM_S;
          w_next  = S_MEM_WR;
        end else begin
          imm_sel = IMM_I;
          w_next  = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEMDATA;
        w_next    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        w_next    = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_sel   = IMM_I;
        w_next    = S_WB_ALU;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        imm_sel   = IMM_U;
        w_next    = S_WB_ALU;
      end
      S_AUIPC: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        imm_sel   = IMM_U;
        w_next    = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        wb_sel    = WB_ALUOUT;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          w_next = S_TRAP;
        end else begin
          if (branch_taken(funct3, zero, lt, ltu)) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          w_next = S_FETCH;
        end
      end
      S_JAL: begin
        // PC already holds OldPC+4, which is the link value written back.
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        imm_sel   = IMM_UJ;
        pc_write  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_sel   = IMM_I;
        if (funct3 == 3'b000) begin
          reg_write = 1'b1;
          wb_sel    = WB_PC;
          pc_write  = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each cycle the full output
// bundle is compared against hand-written vectors.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rstN;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zero, lt, ltu, mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write;
  logic [1:0] wb_sel;
  logic [2:0] imm_sel;
  logic [1:0] alu_src_a, alu_src_b;
  logic [3:0] alu_ctrl;
  logic       illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rstN(rstN), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .illegal(illegal)
  );

  // Bundle: {req,we,addr_sel,ir_wr,pc_wr,pc_src,reg_wr, wb[2], imm[3], a[2], b[2], alu[4], illegal}
  // imm: I0 S1 SB2 U3 UJ4; a: PC0 OldPC1 rs1 2 zero3; b: rs2 0 imm1 four2
  // alu: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
  logic [20:0] outs;
  assign outs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
                 wb_sel, imm_sel, alu_src_a, alu_src_b, alu_ctrl, illegal};

  localparam logic [20:0] E_FETCH     = {7'b1000000, 2'd0, 3'd0, 2'd0, 2'd2, 4'd0, 1'b0};
  localparam logic [20:0] E_FETCH_RDY = {7'b1001100, 2'd0, 3'd0, 2'd0, 2'd2, 4'd0, 1'b0};
  localparam logic [20:0] E_DECODE    = {7'b0000000, 2'd0, 3'd2, 2'd1, 2'd1, 4'd0, 1'b0};
  localparam logic [20:0] E_WB_ALU    = {7'b0000001, 2'd0, 3'd0, 2'd0, 2'd0, 4'd0, 1'b0};
  localparam logic [20:0] E_MADDR_LD  = {7'b0000000, 2'd0, 3'd0, 2'd2, 2'd1, 4'd0, 1'b0};
  localparam logic [20:0] E_MADDR_ST  = {7'b0000000, 2'd0, 3'd1, 2'd2, 2'd1, 4'd0, 1'b0};
  localparam logic [20:0] E_MEM_RD    = {7'b1010000, 2'd0, 3'd0, 2'd0, 2'd0, 4'd0, 1'b0};
  localparam logic [20:0] E_MEM_WR    = {7'b1110000, 2'd0, 3'd0, 2'd0, 2'd0, 4'd0, 1'b0};
  localparam logic [20:0] E_WB_MEM    = {7'b0000001, 2'd1, 3'd0, 2'd0, 2'd0, 4'd0, 1'b0};
  localparam logic [20:0] E_BR_TAKEN  = {7'b0000110, 2'd0, 3'd0, 2'd2, 2'd0, 4'd1, 1'b0};
  localparam logic [20:0] E_BR_NT     = {7'b0000000, 2'd0, 3'd0, 2'd2, 2'd0, 4'd1, 1'b0};
  localparam logic [20:0] E_JAL       = {7'b0000101, 2'd2, 3'd4, 2'd1, 2'd1, 4'd0, 1'b0};
  localparam logic [20:0] E_JALR      = {7'b0000101, 2'd2, 3'd0, 2'd2, 2'd1, 4'd0, 1'b0};
  localparam logic [20:0] E_TRAP      = {7'b0000000, 2'd0, 3'd0, 2'd0, 2'd0, 4'd0, 1'b1};

  task automatic set_insn(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_5 = f7;
  endtask

  task automatic test_reset();
    @(negedge clk); rstN = 1'b0; mem_ready = 1'b1;
    @(negedge clk); rstN = 1'b1; mem_ready = 1'b0; #1;
    n_tests++;
    if (outs !== E_FETCH) begin
      n_fail++; $display("FAIL reset_outputs got %h want %h", outs, E_FETCH);
    end
    n_tests++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_illegal got %b want 0", illegal);
    end
  endtask

  task automatic test_add();
    logic [20:0] ex [5];
    logic        rd [5];
    ex = '{E_FETCH_RDY, E_DECODE, {7'b0, 2'd0, 3'd0, 2'd2, 2'd0, 4'd0, 1'b0}, E_WB_ALU, E_FETCH};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    set_insn(7'b0110011, 3'b000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); mem_ready = rd[c]; #1;
      n_tests++;
      if (outs !== ex[c]) begin
        n_fail++; $display("FAIL add cycle%0d got %h want %h", c + 1, outs, ex[c]);
      end
    end
  endtask

  task automatic test_load();
    logic [20:0] ex [9];
    logic        rd [9];
    ex = '{E_FETCH, E_FETCH_RDY, E_DECODE, E_MADDR_LD, E_MEM_RD, E_MEM_RD, E_MEM_RD,
           E_WB_MEM, E_FETCH};
    rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    set_insn(7'b0000011, 3'b010, 1'b0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); mem_ready = rd[c]; #1;
      n_tests++;
      if (outs !== ex[c]) begin
        n_fail++; $display("FAIL lw cycle%0d got %h want %h", c, outs, ex[c]);
      end
    end
  endtask

  task automatic test_store();
    logic [20:0] ex [6];
    logic        rd [6];
    ex = '{E_FETCH_RDY, E_DECODE, E_MADDR_ST, E_MEM_WR, E_MEM_WR, E_FETCH};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    set_insn(7'b0100011, 3'b010, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); mem_ready = rd[c]; #1;
      n_tests++;
      if (outs !== ex[c]) begin
        n_fail++; $display("FAIL sw cycle%0d got %h want %h", c, outs, ex[c]);
      end
    end
  endtask

  task automatic test_branch();
    // {funct3, zero, lt, ltu, taken}
    logic [6:0] tbl [7];
    logic [20:0] ex;
    tbl = '{{3'b000, 1'b1, 1'b0, 1'b0, 1'b1},   // BEQ equal
            {3'b001, 1'b1, 1'b0, 1'b0, 1'b0},   // BNE equal
            {3'b100, 1'b0, 1'b1, 1'b0, 1'b1},   // BLT less
            {3'b101, 1'b0, 1'b1, 1'b0, 1'b0},   // BGE less
            {3'b110, 1'b0, 1'b1, 1'b0, 1'b0},   // BLTU not less unsigned
            {3'b111, 1'b0, 1'b1, 1'b0, 1'b1},   // BGEU not less unsigned
            {3'b000, 1'b0, 1'b0, 1'b1, 1'b0}};  // BEQ unequal
    for (int i = 0; i < 7; i++) begin
      set_insn(7'b1100011, tbl[i][6:4], 1'b0);
      zero = tbl[i][3]; lt = tbl[i][2]; ltu = tbl[i][1];
      ex = tbl[i][0] ? E_BR_TAKEN : E_BR_NT;
      @(negedge clk); mem_ready = 1'b1; #1;
      n_tests++;
      if (outs !== E_FETCH_RDY) begin
        n_fail++; $display("FAIL br%0d fetch got %h want %h", i, outs, E_FETCH_RDY);
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      n_tests++;
      if (outs !== E_DECODE) begin
        n_fail++; $display("FAIL br%0d decode got %h want %h", i, outs, E_DECODE);
      end
      @(negedge clk); #1;
      n_tests++;
      if (outs !== ex) begin
        n_fail++; $display("FAIL br%0d branch got %h want %h", i, outs, ex);
      end
      @(negedge clk); #1;
      n_tests++;
      if (outs !== E_FETCH) begin
        n_fail++; $display("FAIL br%0d back_to_fetch got %h want %h", i, outs, E_FETCH);
      end
    end
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
  endtask

  task automatic test_alu_ops();
    // {opcode, funct3, funct7_5} and the EXEC-state vector each must produce
    logic [10:0] ins [8];
    logic [20:0] ex  [8];
    ins = '{{7'b0110011, 3'b000, 1'b1}, {7'b0110011, 3'b101, 1'b1}, {7'b0110011, 3'b011, 1'b0},
            {7'b0010011, 3'b000, 1'b1}, {7'b0010011, 3'b101, 1'b1}, {7'b0010011, 3'b110, 1'b0},
            {7'b0110111, 3'b000, 1'b0}, {7'b0010111, 3'b000, 1'b0}};
    ex  = '{{7'b0, 2'd0, 3'd0, 2'd2, 2'd0, 4'd1, 1'b0},   // SUB
            {7'b0, 2'd0, 3'd0, 2'd2, 2'd0, 4'd7, 1'b0},   // SRA
            {7'b0, 2'd0, 3'd0, 2'd2, 2'd0, 4'd4, 1'b0},   // SLTU
            {7'b0, 2'd0, 3'd0, 2'd2, 2'd1, 4'd0, 1'b0},   // ADDI, bit30 ignored
            {7'b0, 2'd0, 3'd0, 2'd2, 2'd1, 4'd7, 1'b0},   // SRAI
            {7'b0, 2'd0, 3'd0, 2'd2, 2'd1, 4'd8, 1'b0},   // ORI
            {7'b0, 2'd0, 3'd3, 2'd3, 2'd1, 4'd0, 1'b0},   // LUI
            {7'b0, 2'd0, 3'd3, 2'd1, 2'd1, 4'd0, 1'b0}};  // AUIPC
    for (int i = 0; i < 8; i++) begin
      set_insn(ins[i][10:4], ins[i][3:1], ins[i][0]);
      @(negedge clk); mem_ready = 1'b1; #1;
      @(negedge clk); mem_ready = 1'b0; #1;
      @(negedge clk); #1;
      n_tests++;
      if (outs !== ex[i]) begin
        n_fail++; $display("FAIL alu%0d exec got %h want %h", i, outs, ex[i]);
      end
      @(negedge clk); #1;
      n_tests++;
      if (outs !== E_WB_ALU) begin
        n_fail++; $display("FAIL alu%0d wb got %h want %h", i, outs, E_WB_ALU);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    logic [20:0] ex [4];
    ex = '{E_FETCH_RDY, E_DECODE, E_JAL, E_FETCH};
    set_insn(7'b1101111, 3'b000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); mem_ready = (c == 0); #1;
      n_tests++;
      if (outs !== ex[c]) begin
        n_fail++; $display("FAIL jal cycle%0d got %h want %h", c, outs, ex[c]);
      end
    end
    ex = '{E_FETCH_RDY, E_DECODE, E_JALR, E_FETCH};
    set_insn(7'b1100111, 3'b000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); mem_ready = (c == 0); #1;
      n_tests++;
      if (outs !== ex[c]) begin
        n_fail++; $display("FAIL jalr cycle%0d got %h want %h", c, outs, ex[c]);
      end
    end
  endtask

  task automatic test_jalr_bad();
    set_insn(7'b1100111, 3'b001, 1'b0);
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    n_tests++;
    if ({pc_write, reg_write, illegal} !== 3'b000) begin
      n_fail++; $display("FAIL jalr_bad_no_write got %b want 000", {pc_write, reg_write, illegal});
    end
    @(negedge clk); #1;
    n_tests++;
    if (outs !== E_TRAP) begin
      n_fail++; $display("FAIL jalr_bad_trap got %h want %h", outs, E_TRAP);
    end
    @(negedge clk); rstN = 1'b0;
    @(negedge clk); rstN = 1'b1; #1;
    n_tests++;
    if (outs !== E_FETCH) begin
      n_fail++; $display("FAIL jalr_bad_recover got %h want %h", outs, E_FETCH);
    end
  endtask

  task automatic test_trap();
    set_insn(7'b0000000, 3'b000, 1'b0);
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    n_tests++;
    if (outs !== E_DECODE) begin
      n_fail++; $display("FAIL trap_decode got %h want %h", outs, E_DECODE);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); mem_ready = c[0]; #1;
      n_tests++;
      if (outs !== E_TRAP) begin
        n_fail++; $display("FAIL trap_hold%0d got %h want %h", c, outs, E_TRAP);
      end
    end
    @(negedge clk); rstN = 1'b0; mem_ready = 1'b0;
    @(negedge clk); rstN = 1'b1; #1;
    n_tests++;
    if (outs !== E_FETCH) begin
      n_fail++; $display("FAIL trap_reset got %h want %h", outs, E_FETCH);
    end
    // Reserved branch funct3 traps without touching the PC.
    set_insn(7'b1100011, 3'b010, 1'b0);
    zero = 1'b1;
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    n_tests++;
    if (outs !== E_BR_NT) begin
      n_fail++; $display("FAIL br010_branch got %h want %h", outs, E_BR_NT);
    end
    @(negedge clk); #1;
    n_tests++;
    if (outs !== E_TRAP) begin
      n_fail++; $display("FAIL br010_trap got %h want %h", outs, E_TRAP);
    end
    zero = 1'b0;
    @(negedge clk); rstN = 1'b0;
    @(negedge clk); rstN = 1'b1; #1;
  endtask

  task automatic test_reset_mid_write();
    set_insn(7'b0100011, 3'b010, 1'b0);
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_tests++;
    if (outs !== E_MEM_WR) begin
      n_fail++; $display("FAIL midwr_wait got %h want %h", outs, E_MEM_WR);
    end
    @(negedge clk); rstN = 1'b0; #1;
    n_tests++;
    if (outs !== E_MEM_WR) begin
      n_fail++; $display("FAIL midwr_hold got %h want %h", outs, E_MEM_WR);
    end
    @(negedge clk); rstN = 1'b1; #1;
    n_tests++;
    if (outs !== E_FETCH) begin
      n_fail++; $display("FAIL midwr_reset got %h want %h", outs, E_FETCH);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rstN = 1'b0; mem_ready = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_alu_ops();
    test_jumps();
    test_jalr_bad();
    test_trap();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
